// File: rtl/sr_latch_bank_driver.sv
// Gated-SR latch bank write driver: turns parallel writes into SETUP/STROBE/HOLD
// S/R/gate sequences, touching only bits that differ from the shadow copy.
// Optional readback checking is built when SR_READBACK_CHECK_EN is defined.
module sr_latch_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
`ifdef SR_READBACK_CHECK_EN
  input  logic [WIDTH-1:0] q_fb,
  output logic             err,
`endif
  output logic             wr_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             gate,
  output logic             busy,
  output logic [WIDTH-1:0] q_model
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] req, req_n, s_n, r_n, q_n, set_m, rst_m;
  logic             gate_n, busy_n, ready_n, accept;

  assign accept = wr_valid & wr_ready;
  // Disjoint by construction, so S and R can never be high together.
  assign set_m  = wr_data & ~q_model;
  assign rst_m  = ~wr_data & q_model;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req;
    s_n     = s;
    r_n     = r;
    gate_n  = gate;
    busy_n  = busy;
    q_n     = q_model;
    ready_n = wr_ready;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          req_n = wr_data;
          if ((set_m | rst_m) != '0) begin
            state_n = SETUP;
            s_n     = set_m;
            r_n     = rst_m;
            busy_n  = 1'b1;
            cnt_n   = SETUP_LD;
            ready_n = 1'b0;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          gate_n  = 1'b1;
          cnt_n   = PULSE_LD;
        end else cnt_n = cnt - 1'b1;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          gate_n  = 1'b0;
          cnt_n   = HOLD_LD;
        end else cnt_n = cnt - 1'b1;
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          s_n     = '0;
          r_n     = '0;
          busy_n  = 1'b0;
          q_n     = req;
          ready_n = 1'b1;
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req      <= '0;
      s        <= '0;
      r        <= '0;
      gate     <= 1'b0;
      busy     <= 1'b0;
      q_model  <= '0;
      wr_ready <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req      <= req_n;
      s        <= s_n;
      r        <= r_n;
      gate     <= gate_n;
      busy     <= busy_n;
      q_model  <= q_n;
      wr_ready <= ready_n;
    end
  end

`ifdef SR_READBACK_CHECK_EN
  logic done;
  assign done = (state == HOLD) && (cnt == '0);

  // Sticky until reset: a failed write stays visible to software.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (done && (q_fb != req)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sr_latch_bank_driver.sv
// Directed bench for sr_latch_bank_driver: vector table of writes plus
// hand sequences for back-to-back requests, mid-strobe reset and readback.
module tb_sr_latch_bank_driver;
  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = '0;
  logic       wr_ready, gate, busy;
  logic [3:0] s, r, q_model;
`ifdef SR_READBACK_CHECK_EN
  logic [3:0] q_fb = '0;
  logic       err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sr_latch_bank_driver dut (
    .clk1(clk1), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef SR_READBACK_CHECK_EN
    .q_fb(q_fb), .err(err),
`endif
    .wr_ready(wr_ready), .s(s), .r(r), .gate(gate), .busy(busy), .q_model(q_model)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous invariants: S/R disjoint, S/R frozen while gate is high.
  logic [3:0] s_prev = '0, r_prev = '0;
  logic       gate_prev = 1'b0;
  always @(negedge clk1) begin
    chk("s_and_r_disjoint", {28'd0, s & r}, 32'd0);
    if (gate && gate_prev) chk("sr_stable_in_gate", {24'd0, s, r}, {24'd0, s_prev, r_prev});
    s_prev    <= s;
    r_prev    <= r;
    gate_prev <= gate;
  end

  typedef struct {
    logic [3:0] d;
    logic [3:0] es;
    logic [3:0] er;
    logic [3:0] eq;
    bit         skip;
  } vec_t;

  vec_t vecs[5];

  // Called at a negedge with the DUT idle; returns at a negedge after completion.
  task automatic write_check(input logic [3:0] d, input logic [3:0] es, input logic [3:0] er,
                             input logic [3:0] eq, input bit skip);
    chk("ready_before_write", {31'd0, wr_ready}, 32'd1);
`ifdef SR_READBACK_CHECK_EN
    q_fb = d;
`endif
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk1);
    wr_valid = 1'b0;
    if (skip) begin
      chk("skip_busy", {31'd0, busy}, 32'd0);
      chk("skip_gate", {31'd0, gate}, 32'd0);
      chk("skip_ready", {31'd0, wr_ready}, 32'd1);
      chk("skip_s", {28'd0, s}, 32'd0);
      chk("skip_q", {28'd0, q_model}, {28'd0, eq});
      @(negedge clk1);
      chk("skip_gate_later", {31'd0, gate}, 32'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("seq_s", {28'd0, s}, {28'd0, es});
        chk("seq_r", {28'd0, r}, {28'd0, er});
        chk("seq_busy", {31'd0, busy}, 32'd1);
        chk("seq_ready", {31'd0, wr_ready}, 32'd0);
        chk("seq_gate", {31'd0, gate}, {31'd0, (k == 1 || k == 2)});
        @(negedge clk1);
      end
      chk("end_s", {28'd0, s}, 32'd0);
      chk("end_r", {28'd0, r}, 32'd0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_gate", {31'd0, gate}, 32'd0);
      chk("end_ready", {31'd0, wr_ready}, 32'd1);
      chk("end_q", {28'd0, q_model}, {28'd0, eq});
    end
  endtask

  initial begin
    vecs[0] = '{d: 4'b1010, es: 4'b1010, er: 4'b0000, eq: 4'b1010, skip: 1'b0};
    vecs[1] = '{d: 4'b0110, es: 4'b0100, er: 4'b1000, eq: 4'b0110, skip: 1'b0};
    vecs[2] = '{d: 4'b0110, es: 4'b0000, er: 4'b0000, eq: 4'b0110, skip: 1'b1};
    vecs[3] = '{d: 4'b0000, es: 4'b0000, er: 4'b0110, eq: 4'b0000, skip: 1'b0};
    vecs[4] = '{d: 4'b1111, es: 4'b1111, er: 4'b0000, eq: 4'b1111, skip: 1'b0};

    // Reset state
    @(negedge clk1);
    @(negedge clk1);
    chk("rst_s", {28'd0, s}, 32'd0);
    chk("rst_r", {28'd0, r}, 32'd0);
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_q", {28'd0, q_model}, 32'd0);
`ifdef SR_READBACK_CHECK_EN
    chk("rst_err", {31'd0, err}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk1);
    chk("ready_after_release", {31'd0, wr_ready}, 32'd1);

    for (int i = 0; i < 5; i++)
      write_check(vecs[i].d, vecs[i].es, vecs[i].er, vecs[i].eq, vecs[i].skip);

    // Held request with changing data: only the accepted value lands.
`ifdef SR_READBACK_CHECK_EN
    q_fb = 4'b0001;
`endif
    wr_valid = 1'b1;
    wr_data  = 4'b0001;
    @(negedge clk1);
    chk("held_s", {28'd0, s}, 32'd0);
    chk("held_r", {28'd0, r}, {28'd0, 4'b1110});
    wr_data = 4'b0111;
    @(negedge clk1);
    wr_data = 4'b0011;
    @(negedge clk1);
    wr_data = 4'b1100;
    @(negedge clk1);
    chk("held_r_frozen", {28'd0, r}, {28'd0, 4'b1110});
    wr_data = 4'b1001;
    @(negedge clk1);
    chk("held_q", {28'd0, q_model}, {28'd0, 4'b0001});
    chk("held_ready_back", {31'd0, wr_ready}, 32'd1);
`ifdef SR_READBACK_CHECK_EN
    q_fb = 4'b1001;
`endif
    @(negedge clk1);
    wr_valid = 1'b0;
    chk("next_busy", {31'd0, busy}, 32'd1);
    chk("next_s", {28'd0, s}, {28'd0, 4'b1000});
    chk("next_r", {28'd0, r}, 32'd0);
    repeat (4) @(negedge clk1);
    chk("next_q", {28'd0, q_model}, {28'd0, 4'b1001});
    chk("next_busy_end", {31'd0, busy}, 32'd0);

    // Reset during STROBE
    wr_valid = 1'b1;
    wr_data  = 4'b0110;
    @(negedge clk1);
    wr_valid = 1'b0;
    @(negedge clk1);
    chk("pre_rst_gate", {31'd0, gate}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gate", {31'd0, gate}, 32'd0);
    chk("async_s", {28'd0, s}, 32'd0);
    chk("async_r", {28'd0, r}, 32'd0);
    chk("async_q", {28'd0, q_model}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_ready", {31'd0, wr_ready}, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("ready_after_mid_rst", {31'd0, wr_ready}, 32'd1);
    write_check(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    write_check(4'b0101, 4'b0101, 4'b0000, 4'b0101, 1'b0);

`ifdef SR_READBACK_CHECK_EN
    chk("err_clear", {31'd0, err}, 32'd0);
    wr_valid = 1'b1;
    wr_data  = 4'b1111;
    q_fb     = 4'b1101;
    @(negedge clk1);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk1);
    chk("err_before_done", {31'd0, err}, 32'd0);
    @(negedge clk1);
    chk("err_set", {31'd0, err}, 32'd1);
    write_check(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0);
    chk("err_sticky", {31'd0, err}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
